// File: rtl/fxp_div_pkg.sv
// rtl/fxp_div_pkg.sv - shared state encoding and saturation limits for the fixed-point divider
package fxp_div_pkg;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  function automatic logic [63:0] fxp_max(input int width);
    return (64'd1 << (width - 1)) - 64'd1;
  endfunction

  // Bit pattern of -2^(width-1); also the largest magnitude a negative result may carry.
  function automatic logic [63:0] fxp_min(input int width);
    return 64'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/fxp_div_fix.sv
// rtl/fxp_div_fix.sv - combinational sign, rounding and saturation stage for the divider quotient
module fxp_div_fix
  import fxp_div_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int ROUND = 0,
  parameter int MAG_W = 24
) (
  input  logic [MAG_W-1:0] i_mag,
  input  logic             i_neg,
  input  logic             i_dvd_neg,
  input  logic             i_div_zero,
  output logic [WIDTH-1:0] o_quotient,
  output logic             o_overflow,
  output logic             o_div_zero
);

  localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(fxp_max(WIDTH));
  localparam logic [WIDTH-1:0] MIN_Q   = WIDTH'(fxp_min(WIDTH));
  localparam logic [MAG_W-1:0] MAX_MAG = MAG_W'(fxp_max(WIDTH));
  localparam logic [MAG_W-1:0] MIN_MAG = MAG_W'(fxp_min(WIDTH));
  localparam logic [WIDTH-1:0] ZERO_W  = '0;

  logic [MAG_W-1:0] mag_r;

  always_comb begin
    mag_r      = i_mag;
    o_quotient = '0;
    o_overflow = 1'b0;
    o_div_zero = 1'b0;
    // The extra LSB is the half bit: adding it before dropping rounds the magnitude half-up.
    if (ROUND != 0) begin
      mag_r = (i_mag >> 1) + MAG_W'(i_mag[0]);
    end
    if (i_div_zero) begin
      o_div_zero = 1'b1;
      o_overflow = 1'b1;
      o_quotient = i_dvd_neg ? MIN_Q : MAX_Q;
    end else if (i_neg) begin
      if (mag_r > MIN_MAG) begin
        o_overflow = 1'b1;
        o_quotient = MIN_Q;
      end else begin
        o_quotient = ZERO_W - mag_r[WIDTH-1:0];
      end
    end else begin
      if (mag_r > MAX_MAG) begin
        o_overflow = 1'b1;
        o_quotient = MAX_Q;
      end else begin
        o_quotient = mag_r[WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/fxp_div_stream.sv
// rtl/fxp_div_stream.sv - signed fixed-point restoring divider with valid/ready handshakes and tag
module fxp_div_stream
  import fxp_div_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int FRAC  = 8,
  parameter int ROUND = 0,
  parameter int TAG_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_quotient,
  output logic [TAG_W-1:0] o_tag,
  output logic             o_overflow,
  output logic             o_div_zero
);

  localparam int ITERS = WIDTH + FRAC + ROUND;
  localparam int SH    = FRAC + ROUND;
  localparam int CNT_W = $clog2(ITERS + 1);
  localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [ITERS-1:0] nq_q, nq_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             neg_q, neg_d;
  logic             dvd_neg_q, dvd_neg_d;
  logic             zero_q, zero_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;
  logic             ready_q, ready_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic             ovf_q, ovf_d;
  logic             dz_q, dz_d;

  logic [WIDTH-1:0] abs_dvd, abs_dvs;
  logic [WIDTH:0]   rem_sh, rem_sub;
  logic             rem_ge;
  logic [WIDTH-1:0] fix_quo;
  logic             fix_ovf, fix_dz;
  logic             unused_rem_msb;

  // Remainder stays below the divisor (<= 2^(WIDTH-1)), so its top bit is always clear.
  assign unused_rem_msb = rem_q[WIDTH];

  assign abs_dvd = i_dividend[WIDTH-1] ? (~i_dividend + ONE_W) : i_dividend;
  assign abs_dvs = i_divisor[WIDTH-1]  ? (~i_divisor + ONE_W)  : i_divisor;
  assign rem_sh  = {rem_q[WIDTH-1:0], nq_q[ITERS-1]};
  assign rem_ge  = rem_sh >= {1'b0, dvs_q};
  assign rem_sub = rem_sh - {1'b0, dvs_q};

  fxp_div_fix #(
    .WIDTH (WIDTH),
    .ROUND (ROUND),
    .MAG_W (ITERS)
  ) u_fix (
    .i_mag      (nq_q),
    .i_neg      (neg_q),
    .i_dvd_neg  (dvd_neg_q),
    .i_div_zero (zero_q),
    .o_quotient (fix_quo),
    .o_overflow (fix_ovf),
    .o_div_zero (fix_dz)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    nq_d      = nq_q;
    dvs_d     = dvs_q;
    neg_d     = neg_q;
    dvd_neg_d = dvd_neg_q;
    zero_d    = zero_q;
    tag_d     = tag_q;
    out_tag_d = out_tag_q;
    ready_d   = ready_q;
    valid_d   = valid_q;
    quo_d     = quo_q;
    ovf_d     = ovf_q;
    dz_d      = dz_q;
    case (state_q)
      IDLE: begin
        if (i_valid && ready_q) begin
          state_d   = CALC;
          ready_d   = 1'b0;
          cnt_d     = '0;
          rem_d     = '0;
          nq_d      = ITERS'(abs_dvd) << SH;
          dvs_d     = abs_dvs;
          neg_d     = i_dividend[WIDTH-1] ^ i_divisor[WIDTH-1];
          dvd_neg_d = i_dividend[WIDTH-1];
          zero_d    = (i_divisor == '0);
          tag_d     = i_tag;
        end
      end
      CALC: begin
        // Numerator bits shift out the top while quotient bits fill in from the bottom.
        rem_d = rem_ge ? rem_sub : rem_sh;
        nq_d  = {nq_q[ITERS-2:0], rem_ge};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(ITERS - 1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        quo_d     = fix_quo;
        ovf_d     = fix_ovf;
        dz_d      = fix_dz;
        out_tag_d = tag_q;
        valid_d   = 1'b1;
        state_d   = DONE;
      end
      DONE: begin
        if (i_ready) begin
          valid_d = 1'b0;
          ready_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      nq_q      <= '0;
      dvs_q     <= '0;
      neg_q     <= 1'b0;
      dvd_neg_q <= 1'b0;
      zero_q    <= 1'b0;
      tag_q     <= '0;
      out_tag_q <= '0;
      ready_q   <= 1'b1;
      valid_q   <= 1'b0;
      quo_q     <= '0;
      ovf_q     <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      nq_q      <= nq_d;
      dvs_q     <= dvs_d;
      neg_q     <= neg_d;
      dvd_neg_q <= dvd_neg_d;
      zero_q    <= zero_d;
      tag_q     <= tag_d;
      out_tag_q <= out_tag_d;
      ready_q   <= ready_d;
      valid_q   <= valid_d;
      quo_q     <= quo_d;
      ovf_q     <= ovf_d;
      dz_q      <= dz_d;
    end
  end

  assign o_ready    = ready_q;
  assign o_valid    = valid_q;
  assign o_quotient = quo_q;
  assign o_tag      = out_tag_q;
  assign o_overflow = ovf_q;
  assign o_div_zero = dz_q;

endmodule
